// File: rtl/tqvp_ws2812b_pkg.sv
// Shared definitions for the WS2812B driver and receiver peripherals.
// Contents:
//   - byte register map addresses (driver names, receiver aliases)
//   - default pulse timing at a 64 MHz project clock
//   - receiver decoder FSM state encoding
//   - helper that selects a colour byte of a GRB word by register address
package tqvp_ws2812b_pkg;

    // Driver register names; the receiver reuses the same slots.
    localparam logic [3:0] ADDR_READY  = 4'h0;
    localparam logic [3:0] ADDR_PUSH   = 4'h1;
    localparam logic [3:0] ADDR_G      = 4'h2;
    localparam logic [3:0] ADDR_R      = 4'h3;
    localparam logic [3:0] ADDR_B      = 4'h4;
    localparam logic [3:0] ADDR_STATUS = ADDR_READY;
    localparam logic [3:0] ADDR_CTRL   = ADDR_PUSH;
    localparam logic [3:0] ADDR_SKIP   = 4'h5;

    // Timing in 64 MHz clock cycles.
    localparam int RX_PIN_DEF   = 1;
    localparam int T_THRESH_DEF = 38;
    localparam int T_MIN_DEF    = 8;
    localparam int T_MAX_DEF    = 80;
    localparam int T_RESET_DEF  = 3200;
    localparam int CW_DEF       = 12;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } rx_state_e;

    // Colour byte of a GRB word for the G/R/B register addresses, 0 otherwise.
    function automatic logic [7:0] grb_byte(input logic [23:0] w, input logic [3:0] addr);
        logic [7:0] b;
        case (addr)
            ADDR_G:  b = w[23:16];
            ADDR_R:  b = w[15:8];
            ADDR_B:  b = w[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ws2812b_rx_decoder.sv
// WS2812B NRZ bit decoder: edge detect, pulse counter, FSM and shift register.
// Ports:
//   clk, rst_n    project clock, synchronous active-low reset
//   rx_i          synchronized data line
//   word_o        assembled GRB word, valid with word_valid_o
//   word_valid_o  1-cycle strobe on the 24th valid falling edge
//   frame_end_o   1-cycle strobe when the latch low period completes
//   error_o       1-cycle strobe on runt/overlong pulse or truncated word
//   busy_o        a partial word is being assembled
// The strobes are decoded combinationally from the current state so that
// the parent can capture a word on the same edge that ends its last bit.
module ws2812b_rx_decoder
    import tqvp_ws2812b_pkg::*;
#(
    parameter int T_THRESH = T_THRESH_DEF,
    parameter int T_MIN    = T_MIN_DEF,
    parameter int T_MAX    = T_MAX_DEF,
    parameter int T_RESET  = T_RESET_DEF,
    parameter int CW       = CW_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_i,
    output logic [23:0] word_o,
    output logic        word_valid_o,
    output logic        frame_end_o,
    output logic        error_o,
    output logic        busy_o
);

    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_SAT    = {CW{1'b1}};
    localparam logic [CW-1:0] T_THRESH_C = CW'(T_THRESH);
    localparam logic [CW-1:0] T_MIN_C    = CW'(T_MIN);
    localparam logic [CW-1:0] T_MAX_C    = CW'(T_MAX);
    localparam logic [CW-1:0] T_RESET_C  = CW'(T_RESET);

    rx_state_e     state_q;
    logic          rx_prev_q;
    logic [CW-1:0] cnt_q;
    logic [4:0]    bitcnt_q;
    logic [22:0]   shift_q;

    logic          rise_s, fall_s;
    logic          overrun_s, runt_s, bit_ok_s, bit_val_s, latch_s;
    logic [CW-1:0] cnt_inc_s;

    assign rise_s    = rx_i & ~rx_prev_q;
    assign fall_s    = ~rx_i & rx_prev_q;
    assign cnt_inc_s = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;

    // The counter is loaded with 1 on each edge so that it holds the number
    // of cycles spent at the current level, including the edge cycle.
    assign overrun_s = (state_q == ST_HIGH) && (cnt_q > T_MAX_C);
    assign runt_s    = (state_q == ST_HIGH) && !overrun_s && fall_s && (cnt_q < T_MIN_C);
    assign bit_ok_s  = (state_q == ST_HIGH) && !overrun_s && fall_s && (cnt_q >= T_MIN_C);
    assign bit_val_s = (cnt_q >= T_THRESH_C);
    assign latch_s   = (state_q == ST_LOW) && !rise_s && (cnt_q == T_RESET_C);

    assign word_o       = {shift_q, bit_val_s};
    assign word_valid_o = bit_ok_s && (bitcnt_q == 5'd23);
    assign frame_end_o  = latch_s;
    assign error_o      = overrun_s || runt_s || (latch_s && (bitcnt_q != 5'd0));
    assign busy_o       = (bitcnt_q != 5'd0);

    // Edge history, pulse counter, bit assembly and decoder state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_SYNC;
            rx_prev_q <= 1'b0;
            cnt_q     <= CNT_ZERO;
            bitcnt_q  <= 5'd0;
            shift_q   <= 23'd0;
        end else begin
            rx_prev_q <= rx_i;
            case (state_q)
                ST_SYNC: begin
                    // Only a full latch period proves we are between frames.
                    if (rx_i) begin
                        cnt_q <= CNT_ZERO;
                    end else if (cnt_q == (T_RESET_C - CNT_ONE)) begin
                        cnt_q   <= CNT_ZERO;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_inc_s;
                    end
                end
                ST_IDLE: begin
                    if (rise_s) begin
                        cnt_q   <= CNT_ONE;
                        state_q <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (overrun_s) begin
                        bitcnt_q <= 5'd0;
                        cnt_q    <= CNT_ZERO;
                        state_q  <= ST_SYNC;
                    end else if (fall_s) begin
                        cnt_q   <= CNT_ONE;
                        state_q <= ST_LOW;
                        if (runt_s) begin
                            bitcnt_q <= 5'd0;
                        end else begin
                            shift_q  <= word_o[22:0];
                            bitcnt_q <= (bitcnt_q == 5'd23) ? 5'd0 : bitcnt_q + 5'd1;
                        end
                    end else begin
                        cnt_q <= cnt_inc_s;
                    end
                end
                ST_LOW: begin
                    if (rise_s) begin
                        cnt_q   <= CNT_ONE;
                        state_q <= ST_HIGH;
                    end else if (latch_s) begin
                        // A partial word at the latch is discarded.
                        bitcnt_q <= 5'd0;
                        cnt_q    <= CNT_ZERO;
                        state_q  <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_inc_s;
                    end
                end
                default: begin
                    bitcnt_q <= 5'd0;
                    cnt_q    <= CNT_ZERO;
                    state_q  <= ST_SYNC;
                end
            endcase
        end
    end

endmodule

// File: rtl/tqvp_cattuto_ws2812b_receiver.sv
// TinyQV byte peripheral: WS2812B receiver with a 2-word FIFO.
// Ports:
//   clk, rst_n   project clock, synchronous active-low reset
//   ui_in        synchronized PMOD inputs, ui_in[RX_PIN] is the data line
//   uo_out       bit1 = data available, other bits 0 (registered)
//   address      register address
//   data_write   single-cycle write strobe
//   data_in      write data
//   data_out     read data, combinational on address
// Registers: 0 STATUS, 1 CTRL (pop/clear, reads word index), 2/3/4 G/R/B
// of the FIFO head, 5 SKIP.
module tqvp_cattuto_ws2812b_receiver
    import tqvp_ws2812b_pkg::*;
#(
    parameter int RX_PIN   = RX_PIN_DEF,
    parameter int T_THRESH = T_THRESH_DEF,
    parameter int T_MIN    = T_MIN_DEF,
    parameter int T_MAX    = T_MAX_DEF,
    parameter int T_RESET  = T_RESET_DEF,
    parameter int CW       = CW_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    logic [23:0] dec_word_s;
    logic        dec_valid_s, dec_frame_end_s, dec_error_s, dec_busy_s;

    ws2812b_rx_decoder #(
        .T_THRESH (T_THRESH),
        .T_MIN    (T_MIN),
        .T_MAX    (T_MAX),
        .T_RESET  (T_RESET),
        .CW       (CW)
    ) u_decoder (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (ui_in[RX_PIN]),
        .word_o       (dec_word_s),
        .word_valid_o (dec_valid_s),
        .frame_end_o  (dec_frame_end_s),
        .error_o      (dec_error_s),
        .busy_o       (dec_busy_s)
    );

    logic        unused_s;
    assign unused_s = &{1'b0, ui_in};

    logic [23:0] mem_q [0:1];
    logic        head_q, tail_q;
    logic [1:0]  count_q, count_d;
    logic        overflow_q, frame_end_q, error_q;
    logic [7:0]  word_idx_q, skip_q, uo_out_q;

    logic        ctrl_wr_s, clr_s, push_req_s, push_s, pop_s, ovf_set_s;
    logic [23:0] head_word_s;

    assign ctrl_wr_s   = data_write && (address == ADDR_CTRL);
    assign clr_s       = ctrl_wr_s && data_in[1];
    assign head_word_s = (count_q != 2'd0) ? mem_q[head_q] : 24'h000000;
    assign uo_out      = uo_out_q;

    // FIFO push/pop arbitration; a pop frees the slot a same-cycle push needs.
    always_comb begin
        push_req_s = dec_valid_s && (word_idx_q >= skip_q);
        pop_s      = ctrl_wr_s && data_in[0] && (count_q != 2'd0);
        push_s     = push_req_s && ((count_q != 2'd2) || pop_s);
        ovf_set_s  = push_req_s && (count_q == 2'd2) && !pop_s;
        if (push_s && !pop_s) begin
            count_d = count_q + 2'd1;
        end else if (pop_s && !push_s) begin
            count_d = count_q - 2'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Register read mux.
    always_comb begin
        data_out = 8'h00;
        case (address)
            ADDR_STATUS: data_out = {dec_busy_s, 3'b000, error_q, frame_end_q,
                                     overflow_q, (count_q != 2'd0)};
            ADDR_CTRL:   data_out = word_idx_q;
            ADDR_G,
            ADDR_R,
            ADDR_B:      data_out = grb_byte(head_word_s, address);
            ADDR_SKIP:   data_out = skip_q;
            default:     data_out = 8'h00;
        endcase
    end

    // FIFO storage, sticky flags (set wins over clear), word index and SKIP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0]    <= 24'h000000;
            mem_q[1]    <= 24'h000000;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            count_q     <= 2'd0;
            overflow_q  <= 1'b0;
            frame_end_q <= 1'b0;
            error_q     <= 1'b0;
            word_idx_q  <= 8'd0;
            skip_q      <= 8'd0;
            uo_out_q    <= 8'h00;
        end else begin
            if (push_s) begin
                mem_q[tail_q] <= dec_word_s;
                tail_q        <= ~tail_q;
            end
            if (pop_s) begin
                head_q <= ~head_q;
            end
            count_q     <= count_d;
            overflow_q  <= ovf_set_s | (overflow_q & ~clr_s);
            frame_end_q <= dec_frame_end_s | (frame_end_q & ~clr_s);
            error_q     <= dec_error_s | (error_q & ~clr_s);
            if (dec_frame_end_s) begin
                word_idx_q <= 8'd0;
            end else if (dec_valid_s && (word_idx_q != 8'hFF)) begin
                word_idx_q <= word_idx_q + 8'd1;
            end
            if (data_write && (address == ADDR_SKIP)) begin
                skip_q <= data_in;
            end
            uo_out_q <= {6'b000000, (count_d != 2'd0), 1'b0};
        end
    end

endmodule

// File: tb/tb_tqvp_cattuto_ws2812b_receiver.sv
// Directed bench for the WS2812B receiver peripheral.
module tb_tqvp_cattuto_ws2812b_receiver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tqvp_cattuto_ws2812b_receiver dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ui_in[1] = 1'b1;
        tick(b ? 51 : 26);
        ui_in[1] = 1'b0;
        tick(b ? 29 : 54);
    endtask

    task automatic send_bits(input logic [23:0] w, input int n);
        for (int i = 23; i > 23 - n; i--) send_bit(w[i]);
    endtask

    task automatic pulse(input int n);
        ui_in[1] = 1'b1;
        tick(n);
        ui_in[1] = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        tick(1);
        data_write = 1'b0;
        data_in    = 8'h00;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
        address = a;
        #1;
        check(tag, data_out, exp);
    endtask

    initial begin
        rst_n      = 1'b0;
        ui_in      = 8'h00;
        address    = 4'h0;
        data_write = 1'b0;
        data_in    = 8'h00;
        tick(3);
        rst_n = 1'b1;
        rd("reset_status", 4'h0, 8'h00);
        rd("reset_ctrl", 4'h1, 8'h00);
        rd("reset_g", 4'h2, 8'h00);
        check("reset_uo", uo_out, 8'h00);

        // Sync period, then one word and a latch.
        tick(3250);
        send_bits(24'hA53C0F, 24);
        tick(3250);
        rd("w1_status", 4'h0, 8'h05);
        check("w1_uo", uo_out, 8'h02);
        rd("w1_g", 4'h2, 8'hA5);
        rd("w1_r", 4'h3, 8'h3C);
        rd("w1_b", 4'h4, 8'h0F);
        rd("w1_ctrl", 4'h1, 8'h00);
        wr(4'h1, 8'h01);
        rd("w1_pop_status", 4'h0, 8'h04);
        check("w1_pop_uo", uo_out, 8'h00);

        // Overflow: third word dropped; pop+clear in one write.
        wr(4'h1, 8'h02);
        send_bits(24'h111111, 24);
        send_bits(24'h222222, 24);
        send_bits(24'h333333, 24);
        tick(3250);
        rd("ovf_status", 4'h0, 8'h07);
        rd("ovf_g", 4'h2, 8'h11);
        wr(4'h1, 8'h03);
        rd("popclr_status", 4'h0, 8'h01);
        rd("popclr_g", 4'h2, 8'h22);
        rd("popclr_b", 4'h4, 8'h22);
        wr(4'h1, 8'h01);
        rd("empty_status", 4'h0, 8'h00);
        rd("empty_g", 4'h2, 8'h00);

        // SKIP = 2: only words 2 and 3 of the frame are captured.
        wr(4'h5, 8'h02);
        rd("skip_rd", 4'h5, 8'h02);
        send_bits(24'h010203, 24);
        send_bits(24'h040506, 24);
        send_bits(24'h0A0B0C, 24);
        send_bits(24'h0D0E0F, 24);
        rd("skip_idx", 4'h1, 8'h04);
        tick(3250);
        rd("skip_idx_end", 4'h1, 8'h00);
        rd("skip_status", 4'h0, 8'h05);
        rd("skip_g2", 4'h2, 8'h0A);
        rd("skip_b2", 4'h4, 8'h0C);
        wr(4'h1, 8'h01);
        rd("skip_r3", 4'h3, 8'h0E);
        wr(4'h1, 8'h03);
        wr(4'h5, 8'h00);
        rd("skip_done", 4'h0, 8'h00);

        // Runt pulse of 4 cycles.
        pulse(4);
        tick(100);
        rd("runt_status", 4'h0, 8'h08);
        tick(3250);
        rd("runt_latch", 4'h0, 8'h0C);

        // Overlong pulse: decoder resyncs and ignores the following word.
        wr(4'h1, 8'h02);
        pulse(100);
        tick(50);
        rd("long_status", 4'h0, 8'h08);
        send_bits(24'h123456, 24);
        tick(3250);
        rd("long_ignored", 4'h0, 8'h08);

        // Truncated word of 12 bits.
        wr(4'h1, 8'h02);
        send_bits(24'hF0F0F0, 12);
        rd("trunc_busy", 4'h0, 8'h80);
        tick(3250);
        rd("trunc_status", 4'h0, 8'h0C);

        // Reset mid-word: no spurious word afterwards.
        send_bits(24'hFFFFFF, 10);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        rd("midrst_status", 4'h0, 8'h00);
        check("midrst_uo", uo_out, 8'h00);
        send_bits(24'h003FFF, 14);
        tick(3250);
        rd("midrst_after", 4'h0, 8'h00);
        rd("midrst_g", 4'h2, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
